// File: rtl/sim_time_stamper.sv
// rtl/sim_time_stamper.sv - free-running ns/10ps time counter with a single-entry snapshot response buffer
// Time advances by PERIOD_STEPS precision steps per enabled cycle and is never stalled by the handshake.
module sim_time_stamper #(
  parameter int STEPS_PER_NS = 100,
  parameter int PERIOD_STEPS = 1000,
  parameter int NS_W         = 48,
  parameter int FRAC_W       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NS_W-1:0]   rsp_ns,
  output logic [FRAC_W-1:0] rsp_frac,
  output logic              rsp_ovf
);

  localparam int INC_NS = PERIOD_STEPS / STEPS_PER_NS;
  localparam int INC_FR = PERIOD_STEPS % STEPS_PER_NS;

  localparam logic [FRAC_W:0] C_INC_FR = (FRAC_W+1)'(INC_FR);
  localparam logic [FRAC_W:0] C_STEPS  = (FRAC_W+1)'(STEPS_PER_NS);
  localparam logic [NS_W:0]   C_INC_NS = (NS_W+1)'(INC_NS);

  logic [NS_W-1:0]   r_ns;
  logic [FRAC_W-1:0] r_frac;
  logic              r_ovf;

  logic              r_rsp_valid;
  logic [NS_W-1:0]   r_rsp_ns;
  logic [FRAC_W-1:0] r_rsp_frac;
  logic              r_rsp_ovf;

  logic [FRAC_W:0]   w_frac_sum;
  logic              w_carry;
  logic [FRAC_W-1:0] w_frac_nxt;
  logic [NS_W:0]     w_ns_sum;
  logic              w_accept;

  // Fraction sum is one bit wider so the carry compare cannot alias.
  assign w_frac_sum = {1'b0, r_frac} + C_INC_FR;
  assign w_carry    = (w_frac_sum >= C_STEPS);
  assign w_frac_nxt = w_carry ? FRAC_W'(w_frac_sum - C_STEPS) : FRAC_W'(w_frac_sum);
  assign w_ns_sum   = {1'b0, r_ns} + C_INC_NS + {{NS_W{1'b0}}, w_carry};

  assign w_accept   = req_valid && !r_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ns   <= '0;
      r_frac <= '0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_ns   <= '0;
      r_frac <= '0;
      r_ovf  <= 1'b0;
    end else if (en) begin
      r_ns   <= w_ns_sum[NS_W-1:0];
      r_frac <= w_frac_nxt;
      r_ovf  <= r_ovf | w_ns_sum[NS_W];
    end
  end

  // Snapshot takes the pre-update counter, so a same-cycle clear still reports the old time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_ns    <= '0;
      r_rsp_frac  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_ns    <= r_ns;
      r_rsp_frac  <= r_frac;
      r_rsp_ovf   <= r_ovf;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = !r_rsp_valid;
  assign rsp_valid = r_rsp_valid;
  assign rsp_ns    = r_rsp_ns;
  assign rsp_frac  = r_rsp_frac;
  assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_sim_time_stamper.sv
// tb/tb_sim_time_stamper.sv - directed bench for sim_time_stamper over three parameter sets
// dut_a: defaults (10ns), dut_b: PERIOD_STEPS=250 (2.5ns), dut_c: NS_W=8 for wrap; all share stimulus.
module tb_sim_time_stamper;

  logic clk = 1'b0;
  logic rst_n, en, clear, req_valid, rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_ovf;
  logic [47:0] a_rsp_ns;
  logic [6:0]  a_rsp_frac;
  logic        b_req_ready, b_rsp_valid, b_rsp_ovf;
  logic [47:0] b_rsp_ns;
  logic [6:0]  b_rsp_frac;
  logic        c_req_ready, c_rsp_valid, c_rsp_ovf;
  logic [7:0]  c_rsp_ns;
  logic [6:0]  c_rsp_frac;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_time_stamper dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .req_valid(req_valid), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ns(a_rsp_ns), .rsp_frac(a_rsp_frac), .rsp_ovf(a_rsp_ovf)
  );

  sim_time_stamper #(.PERIOD_STEPS(250)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .req_valid(req_valid), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ns(b_rsp_ns), .rsp_frac(b_rsp_frac), .rsp_ovf(b_rsp_ovf)
  );

  sim_time_stamper #(.NS_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .req_valid(req_valid), .req_ready(c_req_ready),
    .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ns(c_rsp_ns), .rsp_frac(c_rsp_frac), .rsp_ovf(c_rsp_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_rsp_valid, a_req_ready, a_rsp_ovf, a_rsp_ns, a_rsp_frac} !== {1'b0, 1'b1, 1'b0, 48'd0, 7'd0}) begin
      errors++;
      $display("FAIL reset_a: valid=%0b ready=%0b ovf=%0b ns=%0d frac=%0d expected 0 1 0 0 0",
               a_rsp_valid, a_req_ready, a_rsp_ovf, a_rsp_ns, a_rsp_frac);
    end
    checks++;
    if ({c_rsp_valid, c_req_ready, c_rsp_ns} !== {1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL reset_c: valid=%0b ready=%0b ns=%0d expected 0 1 0", c_rsp_valid, c_req_ready, c_rsp_ns);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    req_valid = 1'b1;
    checks++;
    if (a_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: rsp_valid=%0b before accept edge, expected 0", a_rsp_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({a_rsp_valid, a_req_ready, a_rsp_ovf, a_rsp_ns, a_rsp_frac} !== {1'b1, 1'b0, 1'b0, 48'd30, 7'd0}) begin
      errors++;
      $display("FAIL basic_a: valid=%0b ready=%0b ovf=%0b ns=%0d frac=%0d expected 1 0 0 30 0",
               a_rsp_valid, a_req_ready, a_rsp_ovf, a_rsp_ns, a_rsp_frac);
    end
    checks++;
    if ({b_rsp_valid, b_rsp_ns, b_rsp_frac} !== {1'b1, 48'd7, 7'd50}) begin
      errors++;
      $display("FAIL basic_frac_b: valid=%0b ns=%0d frac=%0d expected 1 7 50", b_rsp_valid, b_rsp_ns, b_rsp_frac);
    end
    drain();
    checks++;
    if ({a_rsp_valid, a_req_ready, a_rsp_ns} !== {1'b0, 1'b1, 48'd30}) begin
      errors++;
      $display("FAIL basic_drop: valid=%0b ready=%0b ns=%0d expected 0 1 30", a_rsp_valid, a_req_ready, a_rsp_ns);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    en = 1'b1;
    repeat (26) tick();
    en = 1'b0;
    request();
    checks++;
    if ({c_rsp_valid, c_rsp_ovf, c_rsp_ns, c_rsp_frac} !== {1'b1, 1'b1, 8'd4, 7'd0}) begin
      errors++;
      $display("FAIL ovf_c: valid=%0b ovf=%0b ns=%0d frac=%0d expected 1 1 4 0",
               c_rsp_valid, c_rsp_ovf, c_rsp_ns, c_rsp_frac);
    end
    checks++;
    if ({a_rsp_ovf, a_rsp_ns} !== {1'b0, 48'd260}) begin
      errors++;
      $display("FAIL ovf_a_nowrap: ovf=%0b ns=%0d expected 0 260", a_rsp_ovf, a_rsp_ns);
    end
    checks++;
    if ({b_rsp_ns, b_rsp_frac} !== {48'd65, 7'd0}) begin
      errors++;
      $display("FAIL ovf_b_long: ns=%0d frac=%0d expected 65 0", b_rsp_ns, b_rsp_frac);
    end
    drain();
    do_clear();
    request();
    checks++;
    if ({c_rsp_valid, c_rsp_ovf, c_rsp_ns} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL ovf_clear_c: valid=%0b ovf=%0b ns=%0d expected 1 0 0", c_rsp_valid, c_rsp_ovf, c_rsp_ns);
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_clear();
    en = 1'b1;
    req_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({a_rsp_valid, a_req_ready, a_rsp_ns, c_rsp_ns} !== {1'b1, 1'b0, 48'd0, 8'd0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b ns_a=%0d ns_c=%0d expected 1 0 0 0",
                 i, a_rsp_valid, a_req_ready, a_rsp_ns, c_rsp_ns);
      end
    end
    req_valid = 1'b0;
    drain();
    checks++;
    if ({a_rsp_valid, a_req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: valid=%0b ready=%0b expected 0 1", a_rsp_valid, a_req_ready);
    end
    request();
    en = 1'b0;
    checks++;
    if ({a_rsp_valid, a_rsp_ns, a_rsp_frac} !== {1'b1, 48'd70, 7'd0}) begin
      errors++;
      $display("FAIL bp_advanced: valid=%0b ns=%0d frac=%0d expected 1 70 0", a_rsp_valid, a_rsp_ns, a_rsp_frac);
    end
    drain();
  endtask

  task automatic test_clear_capture();
    do_clear();
    en = 1'b1;
    repeat (5) tick();
    clear = 1'b1;
    req_valid = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 1'b0;
    checks++;
    if ({a_rsp_valid, a_rsp_ns} !== {1'b1, 48'd50}) begin
      errors++;
      $display("FAIL clr_cap_a: valid=%0b ns=%0d expected 1 50", a_rsp_valid, a_rsp_ns);
    end
    checks++;
    if ({b_rsp_ns, b_rsp_frac} !== {48'd12, 7'd50}) begin
      errors++;
      $display("FAIL clr_cap_b: ns=%0d frac=%0d expected 12 50", b_rsp_ns, b_rsp_frac);
    end
    drain();
    en = 1'b0;
    request();
    checks++;
    if ({a_rsp_ns, a_rsp_ovf, b_rsp_ns, b_rsp_frac} !== {48'd10, 1'b0, 48'd2, 7'd50}) begin
      errors++;
      $display("FAIL clr_after: ns_a=%0d ovf_a=%0b ns_b=%0d frac_b=%0d expected 10 0 2 50",
               a_rsp_ns, a_rsp_ovf, b_rsp_ns, b_rsp_frac);
    end
    drain();
  endtask

  task automatic test_async_reset();
    do_clear();
    en = 1'b1;
    repeat (2) tick();
    request();
    checks++;
    if ({a_rsp_valid, a_rsp_ns} !== {1'b1, 48'd20}) begin
      errors++;
      $display("FAIL arst_pre: valid=%0b ns=%0d expected 1 20", a_rsp_valid, a_rsp_ns);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rsp_valid, a_req_ready, a_rsp_ns, dut_a.r_ns, b_rsp_valid, dut_b.r_frac} !==
        {1'b0, 1'b1, 48'd0, 48'd0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL arst_now: valid=%0b ready=%0b rsp_ns=%0d ns=%0d valid_b=%0b frac_b=%0d expected 0 1 0 0 0 0",
               a_rsp_valid, a_req_ready, a_rsp_ns, dut_a.r_ns, b_rsp_valid, dut_b.r_frac);
    end
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    request();
    checks++;
    if ({a_rsp_valid, a_rsp_ns, a_rsp_ovf} !== {1'b1, 48'd0, 1'b0}) begin
      errors++;
      $display("FAIL arst_post: valid=%0b ns=%0d ovf=%0b expected 1 0 0", a_rsp_valid, a_rsp_ns, a_rsp_ovf);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_clear_capture();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
